// File: rtl/keypad_debounce.sv
// keypad_debounce: debounces scanner key presses/releases and emits a hex key code with a one-cycle strobe
module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_row,
  input  logic [3:0] key_col,
  output logic       scan_hold,
  output logic [3:0] key_code,
  output logic       key_strobe,
  output logic       key_pressed
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CSAT = CW'(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SMAX = SW'(SETTLE_CYCLES);
  localparam logic [63:0] MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [SW-1:0] settle, settle_n;
  logic [3:0] col, col_n, code_n;
  logic [1:0] row, row_n;
  logic strobe_n, pressed_n;
  function automatic logic onehot(input logic [3:0] x);
    return x != 4'd0 && (x & (x - 4'd1)) == 4'd0;
  endfunction
  function automatic logic [1:0] enc(input logic [3:0] x);
    return x[1] ? 2'd1 : x[2] ? 2'd2 : x[3] ? 2'd3 : 2'd0;
  endfunction
  assign cnt_inc = cnt < CSAT ? cnt + 1'b1 : cnt;
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    settle_n  = settle;
    col_n     = col;
    row_n     = row;
    code_n    = key_code;
    strobe_n  = 1'b0;
    pressed_n = key_pressed;
    case (state)
      IDLE: if (onehot(key_col)) begin
        state_n  = PRESS_DB;
        col_n    = key_col;
        cnt_n    = '0;
        settle_n = '0;
      end
      PRESS_DB:
        if (settle < SMAX) settle_n = settle + 1'b1;
        else if (key_col != col) state_n = IDLE;
        else if (cnt != CMAX) cnt_n = cnt_inc;
        else if (onehot(~key_row)) begin
          row_n     = enc(~key_row);
          code_n    = MAP[{enc(~key_row), enc(col), 2'b00} +: 4];
          strobe_n  = 1'b1;
          pressed_n = 1'b1;
          state_n   = PRESSED;
        end else state_n = IDLE;
      PRESSED: if (key_col == 4'd0) begin
        state_n = REL_DB;
        cnt_n   = '0;
      end
      REL_DB:
        if (key_col == 4'd0) begin
          cnt_n     = cnt_inc;
          state_n   = cnt == CMAX ? IDLE : REL_DB;
          pressed_n = cnt == CMAX ? 1'b0 : key_pressed;
        end else if (key_col == col) state_n = PRESSED;
        else cnt_n = '0;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      settle      <= '0;
      col         <= '0;
      row         <= '0;
      scan_hold   <= 1'b0;
      key_code    <= '0;
      key_strobe  <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      settle      <= settle_n;
      col         <= col_n;
      row         <= row_n;
      scan_hold   <= state_n != IDLE;
      key_code    <= code_n;
      key_strobe  <= strobe_n;
      key_pressed <= pressed_n;
    end
  end
endmodule

// File: tb/tb_keypad_debounce.sv
// tb_keypad_debounce: directed and table-driven checks of keypad_debounce with DEBOUNCE_CYCLES=8, SETTLE_CYCLES=2
module tb_keypad_debounce;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] key_row, key_col, key_code;
  logic scan_hold, key_strobe, key_pressed;
  int errs = 0, checks = 0, nstrobe = 0, s0;
  typedef struct {logic [3:0] row; logic [3:0] col; logic [3:0] code;} vec_t;
  vec_t v [16];
  logic [3:0] exp_code [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  keypad_debounce #(.DEBOUNCE_CYCLES(8), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .key_row(key_row), .key_col(key_col),
    .scan_hold(scan_hold), .key_code(key_code), .key_strobe(key_strobe), .key_pressed(key_pressed)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (key_strobe) nstrobe <= nstrobe + 1;
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 16; i++) begin
      v[i].row  = ~(4'b0001 << (i / 4));
      v[i].col  = 4'b0001 << (i % 4);
      v[i].code = exp_code[i];
    end
    reset = 1'b0; key_row = 4'hF; key_col = 4'h0;
    step(2);
    chk("rst_hold", scan_hold, 0);
    chk("rst_code", key_code, 0);
    chk("rst_strobe", key_strobe, 0);
    chk("rst_pressed", key_pressed, 0);
    reset = 1'b1;
    step(2);
    // clean press r1c2 and latency
    s0 = nstrobe; key_row = 4'b1101; key_col = 4'b0100;
    step(1);  chk("t1_hold_rise", scan_hold, 1);
    step(9);  chk("t1_no_early_strobe", key_strobe, 0);
    step(1);  chk("t1_strobe", key_strobe, 1);
    chk("t1_code", key_code, 6);
    chk("t1_pressed", key_pressed, 1);
    step(19);
    chk("t1_one_strobe", nstrobe - s0, 1);
    chk("t1_still_pressed", key_pressed, 1);
    chk("t1_still_hold", scan_hold, 1);
    // release bounce
    key_col = 4'b0000; step(4); chk("t3_pressed_gap", key_pressed, 1);
    key_col = 4'b0100; step(3); chk("t3_pressed_back", key_pressed, 1);
    key_col = 4'b0000; step(8); chk("t3_pressed_before_rel", key_pressed, 1);
    step(1);
    chk("t3_released", key_pressed, 0);
    chk("t3_hold_drop", scan_hold, 0);
    chk("t3_code_kept", key_code, 6);
    step(1);
    chk("t3_no_extra_strobe", nstrobe - s0, 1);
    // press bounce then stable r0c1
    s0 = nstrobe; key_row = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      key_col = 4'b0010; step(3);
      key_col = 4'b0000; step(3);
    end
    chk("t2_bounce_no_strobe", nstrobe - s0, 0);
    chk("t2_bounce_idle", scan_hold, 0);
    key_col = 4'b0010; step(12);
    chk("t2_stable_strobe", nstrobe - s0, 1);
    chk("t2_code", key_code, 2);
    key_col = 4'b0000; step(10);
    chk("t2_released", key_pressed, 0);
    // ghosting
    s0 = nstrobe; key_col = 4'b0110; step(5);
    chk("t4_ghost_no_hold", scan_hold, 0);
    chk("t4_ghost_no_strobe", nstrobe - s0, 0);
    key_col = 4'b0000; step(1);
    key_row = 4'b0111; key_col = 4'b0001; step(11);
    chk("t4_strobe", key_strobe, 1);
    chk("t4_code", key_code, 4'hE);
    key_col = 4'b1000; step(5);
    chk("t4_second_code", key_code, 4'hE);
    chk("t4_second_pressed", key_pressed, 1);
    chk("t4_second_no_strobe", nstrobe - s0, 1);
    key_col = 4'b0000; step(10);
    chk("t4_released", key_pressed, 0);
    chk("t4_code_kept", key_code, 4'hE);
    // reset in PRESS_DB
    s0 = nstrobe; key_row = 4'b1011; key_col = 4'b1000; step(5);
    chk("t5_hold_before", scan_hold, 1);
    #2 reset = 1'b0;
    #1 chk("t5_hold", scan_hold, 0);
    chk("t5_code", key_code, 0);
    chk("t5_strobe", key_strobe, 0);
    chk("t5_pressed", key_pressed, 0);
    key_col = 4'b0000; step(2);
    reset = 1'b1; step(15);
    chk("t5_no_strobe", nstrobe - s0, 0);
    chk("t5_idle", scan_hold, 0);
    // map sweep
    s0 = nstrobe;
    for (int i = 0; i < 16; i++) begin
      key_row = v[i].row; key_col = v[i].col;
      step(10); chk($sformatf("t6_early_%0d", i), key_strobe, 0);
      step(1);  chk($sformatf("t6_strobe_%0d", i), key_strobe, 1);
      chk($sformatf("t6_code_%0d", i), key_code, v[i].code);
      step(2); key_col = 4'b0000;
      step(9); chk($sformatf("t6_rel_%0d", i), key_pressed, 0);
    end
    step(2);
    chk("t6_strobe_total", nstrobe - s0, 16);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
